fir_inverse_filter: RTL and testbench



---
 rtl/fir_pkg.sv | 8 +
 rtl/fir_inv_mac.sv | 11 +
 rtl/fir_inverse_filter.sv | 89 ++++++++
 tb/tb_fir_inverse_filter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types, default coefficients and FSM states for the FIR datapath.
package fir_pkg;
  localparam int FIR_N = 4;
  localparam int FIR_WIDTH = 16;
  typedef logic [FIR_WIDTH-1:0] coeff_t;
  localparam coeff_t FIR_COEFF_DEFAULT [FIR_N] = '{16'd1, 16'd2, 16'd3, 16'd4};
  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_inv_state_e;
endpackage

// File: rtl/fir_inv_mac.sv
// fir_inv_mac: modular multiply-subtract, acc_out = acc_in - coeff*sample mod 2^WIDTH.
module fir_inv_mac #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] coeff,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] acc_out
);
  assign acc_out = acc_in - coeff * sample;
endmodule

// File: rtl/fir_inverse_filter.sv
// fir_inverse_filter: time-multiplexed inverse of a monic FIR; optional clr port via FIR_INV_CLR_EN.
module fir_inverse_filter
  import fir_pkg::*;
#(
  parameter int N = FIR_N,
  parameter int WIDTH = FIR_WIDTH,
  parameter logic [WIDTH-1:0] CO_EFF [N] = FIR_COEFF_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FIR_INV_CLR_EN
  input  logic             clr,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int KW = $clog2(N);
  if (N < 2 || CO_EFF[0] != WIDTH'(1)) begin : g_bad_cfg
    $error("fir_inverse_filter: need N >= 2 and CO_EFF[0] == 1");
  end
  fir_inv_state_e state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mac_out;
  logic [WIDTH-1:0] hist_q [1:N-1];
  logic [KW-1:0] k_q, k_d;
  logic clr_i, out_hs;
`ifdef FIR_INV_CLR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign out_data = out_valid ? acc_q : '0;
  assign out_hs = out_valid && out_ready;
  fir_inv_mac #(.WIDTH(WIDTH)) u_mac (
    .acc_in (acc_q),
    .coeff  (CO_EFF[k_q]),
    .sample (hist_q[k_q]),
    .acc_out(mac_out)
  );
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    k_d = k_q;
    if (clr_i) begin
      state_d = IDLE;
      acc_d = '0;
      k_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          state_d = MAC;
          acc_d = in_data;
          k_d = KW'(1);
        end
        MAC: begin
          acc_d = mac_out;
          k_d = k_q + KW'(1);
          state_d = k_q == KW'(N - 1) ? OUT : MAC;
        end
        OUT: state_d = out_ready ? IDLE : OUT;
        default: state_d = IDLE;
      endcase
    end
  end
  // history only advances on the output handshake, so a stalled output never disturbs it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      k_q <= '0;
      for (int i = 1; i < N; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      k_q <= k_d;
      if (clr_i) begin
        for (int i = 1; i < N; i++) hist_q[i] <= '0;
      end else if (out_hs) begin
        for (int i = N - 1; i > 1; i--) hist_q[i] <= hist_q[i-1];
        hist_q[1] <= acc_q;
      end
    end
  end
endmodule

// File: tb/tb_fir_inverse_filter.sv
// tb_fir_inverse_filter: scoreboard bench driving FIR-filtered samples and checking recovery.
module tb_fir_inverse_filter;
  localparam int N = 4;
  localparam int W = 16;
  localparam logic [W-1:0] C [N] = '{16'd1, 16'd2, 16'd3, 16'd4};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
`ifdef FIR_INV_CLR_EN
  logic clr = 1'b0;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] xh [1:N-1];

  fir_inverse_filter #(.N(N), .WIDTH(W), .CO_EFF(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef FIR_INV_CLR_EN
    .clr      (clr),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // forward FIR model: y = sum c[k]*x[n-k] mod 2^W
  task automatic fir_fwd(input logic [W-1:0] x, output logic [W-1:0] y);
    y = x;
    for (int k = 1; k < N; k++) y = y + C[k] * xh[k];
    for (int k = N - 1; k > 1; k--) xh[k] = xh[k-1];
    xh[1] = x;
  endtask

  task automatic clear_model();
    sb.delete();
    for (int k = 1; k < N; k++) xh[k] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    #3;
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", out_data, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_raw(input logic [W-1:0] y);
    int c;
    c = 0;
    in_valid = 1'b1;
    in_data = y;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++c > 100) begin
        check("in_ready_timeout", {15'd0, in_ready}, 16'd1);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_x(input logic [W-1:0] x);
    logic [W-1:0] y;
    fir_fwd(x, y);
    sb.push_back(x);
    send_raw(y);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    if (sb.size() != 0) check("drain_timeout", 16'(sb.size()), 16'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int c;
    c = 0;
    while (!out_valid && c < 100) begin
      @(posedge clk);
      #1 c++;
    end
    check("out_valid_wait", {15'd0, out_valid}, 16'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_out", {15'd0, out_valid}, 16'd0);
      else check("out_data", out_data, sb.pop_front());
    end
  end

  initial begin
    logic [W-1:0] x;
    for (int k = 1; k < N; k++) xh[k] = '0;
    do_reset();
    // impulse response with latency and in_ready timing
    sb.push_back(16'h0001);
    send_raw(16'd1);
    repeat (N - 2) @(posedge clk);
    #1;
    check("lat_not_yet", {15'd0, out_valid}, 16'd0);
    check("busy_in_ready", {15'd0, in_ready}, 16'd0);
    @(posedge clk);
    #1 check("lat_valid", {15'd0, out_valid}, 16'd1);
    @(posedge clk);
    #1 check("ready_after_hs", {15'd0, in_ready}, 16'd1);
    sb.push_back(16'hFFFE);
    sb.push_back(16'h0001);
    sb.push_back(16'h0000);
    sb.push_back(16'h0005);
    send_raw(16'd0);
    send_raw(16'd0);
    send_raw(16'd0);
    send_raw(16'd0);
    drain();
    do_reset();
    // round trip of FIR response to 5,0,0,0,0
    for (int i = 0; i < 5; i++) sb.push_back(i == 0 ? 16'd5 : 16'd0);
    send_raw(16'd5);
    send_raw(16'd10);
    send_raw(16'd15);
    send_raw(16'd20);
    send_raw(16'd0);
    drain();
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      x = (i % 37 == 5 || i % 37 == 6) ? 16'hFFFF : 16'($urandom);
      send_x(x);
    end
    drain();
    // back-pressure
    out_ready = 1'b0;
    send_x(16'h1234);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data", out_data, sb[0]);
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      check("bp_valid", {15'd0, out_valid}, 16'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_x(16'hBEEF);
    drain();
    // asynchronous reset in the middle of MAC
    send_raw(16'h5555);
    @(posedge clk);
    #1 rst_n = 1'b0;
    clear_model();
    #2;
    check("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_x(16'd7);
    drain();
`ifdef FIR_INV_CLR_EN
    send_x(16'h0042);
    drain();
    out_ready = 1'b0;
    send_x(16'h0099);
    wait_valid();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    clear_model();
    check("clr_valid", {15'd0, out_valid}, 16'd0);
    out_ready = 1'b1;
    send_x(16'd3);
    drain();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
